// File: rtl/reaction_delay_timer_if.sv
// Handshake bundle between the reaction-game controller and the delay timer.
interface reaction_delay_timer_if #(
    parameter int unsigned WIDTH = 11
) ();
    logic             Start;
    logic             Tick;
    logic             Button;
    logic             Go;
    logic             Early;
    logic             Busy;
    logic [WIDTH-1:0] Delay;
    logic [WIDTH-1:0] Remaining;

    // Controller side: requests rounds, forwards ticks and the button.
    modport master (
        output Start, Tick, Button,
        input  Go, Early, Busy, Delay, Remaining
    );

    // Timer side.
    modport slave (
        input  Start, Tick, Button,
        output Go, Early, Busy, Delay, Remaining
    );
endinterface

// File: rtl/reaction_delay_timer.sv
// Pseudo-random countdown for the reaction-time game: arms on Start, counts
// prescaler ticks down to zero, raises Go, and flags button presses before Go.
module reaction_delay_timer #(
    parameter int unsigned      WIDTH     = 11,
    parameter logic [WIDTH-1:0] MIN_DELAY = WIDTH'(250),
    parameter int unsigned      RAND_BITS = 10,
    parameter logic [10:0]      LFSR_SEED = 11'h5A5
) (
    input  logic                  Clock,
    input  logic                  Reset,
    reaction_delay_timer_if.slave bus
);

    localparam int unsigned      LFSR_W    = 11;
    localparam logic [WIDTH-1:0] RAND_MASK = WIDTH'((64'd1 << RAND_BITS) - 64'd1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_GO    = 2'd2,
        S_EARLY = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [LFSR_W-1:0] lfsr_q, lfsr_d;
    logic [WIDTH-1:0]  delay_q, delay_d;
    logic [WIDTH-1:0]  rem_q, rem_d;
    logic              go_q, go_d;
    logic              early_q, early_d;
    logic              busy_q, busy_d;

    logic [WIDTH:0]    sum_c;
    logic [WIDTH-1:0]  load_c;

    // Load value: floor plus masked LFSR bits, saturating at all-ones.
    always_comb begin
        sum_c  = {1'b0, MIN_DELAY} + {1'b0, WIDTH'(lfsr_q) & RAND_MASK};
        load_c = sum_c[WIDTH] ? '1 : sum_c[WIDTH-1:0];
    end

    // State and output registers; Reset wins over everything.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= S_IDLE;
            lfsr_q  <= LFSR_SEED;
            delay_q <= '0;
            rem_q   <= '0;
            go_q    <= 1'b0;
            early_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            delay_q <= delay_d;
            rem_q   <= rem_d;
            go_q    <= go_d;
            early_q <= early_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state, LFSR and countdown logic.
    always_comb begin
        state_d = state_q;
        delay_d = delay_q;
        rem_d   = rem_q;
        go_d    = go_q;
        early_d = early_q;
        busy_d  = busy_q;
        // x^11 + x^9 + 1, free-running; an all-zero lockup reloads the seed.
        lfsr_d  = (lfsr_q == '0) ? LFSR_SEED : {lfsr_q[LFSR_W-2:0], lfsr_q[10] ^ lfsr_q[8]};

        case (state_q)
            S_IDLE: begin
                if (bus.Start) begin
                    state_d = S_WAIT;
                    delay_d = load_c;
                    rem_d   = load_c;
                    busy_d  = 1'b1;
                end
            end
            S_WAIT: begin
                if (bus.Button) begin
                    state_d = S_EARLY;
                    early_d = 1'b1;
                end else if (rem_q == '0) begin
                    state_d = S_GO;
                    go_d    = 1'b1;
                end else if (bus.Tick) begin
                    rem_d = rem_q - WIDTH'(1);
                    if (rem_q == WIDTH'(1)) begin
                        state_d = S_GO;
                        go_d    = 1'b1;
                    end
                end
            end
            S_GO: begin
                if (bus.Button) begin
                    state_d = S_IDLE;
                    go_d    = 1'b0;
                    busy_d  = 1'b0;
                end
            end
            S_EARLY: begin
                if (bus.Start) begin
                    state_d = S_WAIT;
                    early_d = 1'b0;
                    delay_d = load_c;
                    rem_d   = load_c;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.Go        = go_q;
    assign bus.Early     = early_q;
    assign bus.Busy      = busy_q;
    assign bus.Delay     = delay_q;
    assign bus.Remaining = rem_q;

endmodule

// File: tb/tb_reaction_delay_timer.sv
// Self-checking bench for reaction_delay_timer across four parameter sets.
module tb_reaction_delay_timer;

    localparam int unsigned W    = 11;
    localparam logic [10:0] SEED = 11'h5A5;

    logic Clock = 1'b0;
    logic Reset;
    always #5 Clock = ~Clock;

    reaction_delay_timer_if #(.WIDTH(W)) det_if ();
    reaction_delay_timer_if #(.WIDTH(W)) zero_if ();
    reaction_delay_timer_if #(.WIDTH(W)) sat_if ();
    reaction_delay_timer_if #(.WIDTH(W)) def_if ();

    reaction_delay_timer #(.WIDTH(W), .MIN_DELAY(11'd4), .RAND_BITS(0))
        u_det (.Clock(Clock), .Reset(Reset), .bus(det_if));
    reaction_delay_timer #(.WIDTH(W), .MIN_DELAY(11'd0), .RAND_BITS(0))
        u_zero (.Clock(Clock), .Reset(Reset), .bus(zero_if));
    reaction_delay_timer #(.WIDTH(W), .MIN_DELAY(11'h7FF), .RAND_BITS(10))
        u_sat (.Clock(Clock), .Reset(Reset), .bus(sat_if));
    reaction_delay_timer #(.WIDTH(W))
        u_def (.Clock(Clock), .Reset(Reset), .bus(def_if));

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [10:0] model_lfsr = SEED;

    // One comparison: counted, asserted, reported on failure.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference LFSR: shift left, new bit = bit10 xor bit8; zero reloads the seed.
    function automatic logic [10:0] lfsr_step(input logic [10:0] v);
        if (v == 11'd0) return SEED;
        return {v[9:0], v[10] ^ v[8]};
    endfunction

    // Reference load value: floor plus low random bits, clipped to 2047.
    function automatic int exp_load(input int min_d, input int rbits, input logic [10:0] l);
        int r;
        int s;
        r = (rbits == 0) ? 0 : (int'(l) % (1 << rbits));
        s = min_d + r;
        return (s > 2047) ? 2047 : s;
    endfunction

    // Advance one clock, tracking the reference LFSR, and settle past the edge.
    task automatic step();
        @(posedge Clock);
        model_lfsr = Reset ? SEED : lfsr_step(model_lfsr);
        #1;
    endtask

    initial begin
        int          exp_d;
        int          exp_rem;
        int          cycles;
        logic [10:0] delays [4];
        logic        all_eq;

        Reset = 1'b1;
        det_if.Start = 0;  det_if.Tick = 0;  det_if.Button = 0;
        zero_if.Start = 0; zero_if.Tick = 0; zero_if.Button = 0;
        sat_if.Start = 0;  sat_if.Tick = 0;  sat_if.Button = 0;
        def_if.Start = 0;  def_if.Tick = 0;  def_if.Button = 0;

        // Reset then idle
        step(); step();
        check("rst_go",    32'(det_if.Go), 0);
        check("rst_early", 32'(det_if.Early), 0);
        check("rst_busy",  32'(det_if.Busy), 0);
        check("rst_delay", 32'(det_if.Delay), 0);
        check("rst_rem",   32'(det_if.Remaining), 0);
        check("rst_def",   32'({def_if.Go, def_if.Early, def_if.Busy, def_if.Delay, def_if.Remaining}), 0);
        Reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("idle", 32'({det_if.Go, det_if.Early, det_if.Busy, det_if.Delay, det_if.Remaining}), 0);
        end

        // Deterministic countdown of 4
        det_if.Start = 1; step(); det_if.Start = 0;
        check("cd_busy",  32'(det_if.Busy), 1);
        check("cd_delay", 32'(det_if.Delay), 4);
        check("cd_rem0",  32'(det_if.Remaining), 4);
        for (int k = 1; k <= 4; k++) begin
            for (int g = 0; g < 2; g++) begin
                step();
                check("cd_hold_rem", 32'(det_if.Remaining), 32'(5 - k));
                check("cd_hold_go",  32'(det_if.Go), 0);
            end
            det_if.Tick = 1; step(); det_if.Tick = 0;
            check("cd_rem", 32'(det_if.Remaining), 32'(4 - k));
            check("cd_go",  32'(det_if.Go), (k == 4) ? 1 : 0);
        end
        det_if.Start = 1; det_if.Tick = 1; step(); det_if.Start = 0; det_if.Tick = 0;
        check("go_held",   32'(det_if.Go), 1);
        check("go_delay",  32'(det_if.Delay), 4);
        check("go_early",  32'(det_if.Early), 0);
        det_if.Button = 1; step(); det_if.Button = 0;
        check("btn_go",   32'(det_if.Go), 0);
        check("btn_busy", 32'(det_if.Busy), 0);

        // Zero load reaches Go without a tick
        zero_if.Start = 1; step(); zero_if.Start = 0;
        check("zero_go1",   32'(zero_if.Go), 0);
        check("zero_busy",  32'(zero_if.Busy), 1);
        check("zero_rem",   32'(zero_if.Remaining), 0);
        step();
        check("zero_go2",   32'(zero_if.Go), 1);
        zero_if.Button = 1; step(); zero_if.Button = 0;
        check("zero_done",  32'({zero_if.Go, zero_if.Busy}), 0);

        // Saturating load
        exp_d = exp_load(2047, 10, model_lfsr);
        sat_if.Start = 1; step(); sat_if.Start = 0;
        check("sat_delay", 32'(sat_if.Delay), 32'h7FF);
        check("sat_model", 32'(sat_if.Remaining), 32'(exp_d));

        // Early press: button beats tick, then Start reloads
        det_if.Start = 1; step(); det_if.Start = 0;
        for (int k = 0; k < 2; k++) begin
            det_if.Tick = 1; step(); det_if.Tick = 0;
        end
        check("er_pre_rem", 32'(det_if.Remaining), 2);
        det_if.Button = 1; det_if.Tick = 1; step();
        check("er_early", 32'(det_if.Early), 1);
        check("er_rem",   32'(det_if.Remaining), 2);
        check("er_go",    32'(det_if.Go), 0);
        step(); step(); det_if.Button = 0; det_if.Tick = 0;
        check("er_hold", 32'({det_if.Go, det_if.Early, det_if.Remaining}), 32'({1'b0, 1'b1, 11'd2}));
        det_if.Start = 1; step(); det_if.Start = 0;
        check("er_clear",  32'(det_if.Early), 0);
        check("er_reload", 32'(det_if.Remaining), 4);
        check("er_busy",   32'(det_if.Busy), 1);

        // Reset mid-round with a pending tick
        det_if.Tick = 1; step();
        check("mr_rem3", 32'(det_if.Remaining), 3);
        Reset = 1; step(); Reset = 0; det_if.Tick = 0;
        check("mr_reset", 32'({det_if.Go, det_if.Early, det_if.Busy, det_if.Delay, det_if.Remaining}), 0);
        step();
        check("mr_after", 32'({det_if.Go, det_if.Early, det_if.Busy, det_if.Delay, det_if.Remaining}), 0);

        // Four randomized rounds with default parameters
        for (int r = 0; r < 4; r++) begin
            int gap;
            gap = $urandom_range(1, 40);
            for (int g = 0; g < gap; g++) begin
                def_if.Button = 1'($urandom_range(0, 1));
                step();
                check("rr_idle_busy", 32'(def_if.Busy), 0);
            end
            def_if.Button = 0;
            exp_d = exp_load(250, 10, model_lfsr);
            def_if.Start = 1; step(); def_if.Start = 0;
            delays[r] = def_if.Delay;
            check("rr_delay", 32'(def_if.Delay), 32'(exp_d));
            check("rr_range", 32'(def_if.Delay >= 11'd250 && def_if.Delay <= 11'd1273), 1);
            check("rr_busy",  32'(def_if.Busy), 1);
            exp_rem = exp_d;
            cycles  = 0;
            while (exp_rem > 0 && cycles < 3000) begin
                def_if.Tick = 1'($urandom_range(0, 1));
                if (def_if.Tick) exp_rem--;
                step();
                def_if.Tick = 0;
                cycles++;
                check("rr_rem", 32'(def_if.Remaining), 32'(exp_rem));
                check("rr_go",  32'(def_if.Go), (exp_rem == 0) ? 1 : 0);
                check("rr_excl", 32'(def_if.Go & def_if.Early), 0);
            end
            check("rr_go_reached", 32'(def_if.Go), 1);
            def_if.Button = 1; step(); def_if.Button = 0;
            check("rr_end", 32'({def_if.Go, def_if.Busy}), 0);
        end
        all_eq = (delays[0] == delays[1]) && (delays[1] == delays[2]) && (delays[2] == delays[3]);
        check("rr_differ", 32'(all_eq), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
